p2s_sched: RTL and testbench
============================

# p2s_sched

Round-robin scheduler that shares one `parallel_to_serial` converter among `N_REQ` requesters. It sits directly in front of the converter. Each cycle it is idle it picks one pending requester and latches that requester's word. It then presents the word on `ser_data` with `ser_valid` held high for exactly `DATA_W` cycles, which is the converter's load/shift window, followed by an idle gap. Requesters see a one-cycle `grant` pulse when their word has been taken.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: word width, and the length of the `ser_valid` window in cycles.
- `GAP`, 1: extra idle cycles after each word, 0..15.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; gates new grants only.
- `req`  in  N_REQ  per-requester request, level.
- `req_data`  in  N_REQ*DATA_W  requester i's word at bits [i*DATA_W +: DATA_W].
- `grant`  out  N_REQ  one-hot, one-cycle pulse: word taken.
- `ser_data`  out  DATA_W  word to the converter's `din_parallel`.
- `ser_valid`  out  1  to the converter's `din_valid`.
- `owner`  out  clog2(N_REQ)  index of the current or last winner.
- `busy`  out  1  high in SEND and GAP.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Values while `rst` is high: `grant`=0, `ser_valid`=0, `ser_data`=0, `owner`=0, `busy`=0, state=IDLE, counter=0, pointer=0.
- State IDLE:
  - Arbitration happens if `en`=1 and `req`!=0.
  - Search starts at pointer `ptr` and runs upward, wrapping modulo `N_REQ`. The first set `req` bit wins.
  - On that edge: latch the winner's word into `ser_data` and the winner's index into `owner`.
  - Also on that edge: set `grant[winner]`=1, `ser_valid`=1, counter=0, `ptr`=winner+1 mod `N_REQ`, and go to SEND.
- State SEND:
  - `ser_valid`=1 and `ser_data` is held constant.
  - `grant` returns to 0 after its single cycle.
  - The counter increments each cycle. After `DATA_W` cycles of `ser_valid`, go to GAP if `GAP`>0, otherwise go to IDLE.
  - Leaving SEND drives `ser_valid`=0.
- State GAP: `ser_valid`=0 for `GAP` cycles, then go to IDLE.
- `ser_data` keeps the last word after SEND; it is not cleared.
- Requester contract:
  - Hold `req` and `req_data` stable until `grant` is seen.
  - Keeping `req` high after `grant` requests another word.
  - `req` and `req_data` are sampled only at the arbitration edge.
- `en` falling during SEND or GAP does not truncate the current word; it only blocks the next grant.
- A requester that drops `req` before being granted is simply skipped. This is not an error.

## Timing
- Grant latency: a request present while in IDLE is granted on the next rising edge.
- `grant` and the first `ser_valid` cycle are the same cycle.
- `ser_valid` is high for exactly `DATA_W` consecutive cycles per word.
- Minimum `ser_valid` low between back-to-back words is `GAP`+1 cycles: the GAP cycles plus one IDLE arbitration cycle.
- Throughput is one word per `DATA_W`+`GAP`+1 cycles.
- Wrap-around: with `ptr`=0 after winner `N_REQ`-1, requester 0 has top priority.
- Simultaneous `req` changes during SEND are ignored until IDLE.
- Reset mid-SEND aborts the word immediately (asynchronously) and the pointer returns to 0. The partially shifted word is lost; no retry.

## Configuration
- `P2S_SCHED_RR_EN`, defined: round-robin as above, with `ptr` updated on every grant.
- `P2S_SCHED_RR_EN`, undefined: fixed priority.
  - Lowest set index always wins and `ptr` is not instantiated.
  - All other timing is identical.

## Test plan
- Single requester (N_REQ=4, DATA_W=8, GAP=1): `req[0]`=1 with 8'hF0, then dropped after `grant` → `grant`=4'b0001 for one cycle; `ser_valid` high 8 cycles with `ser_data`=8'hF0 and `owner`=0; `busy` low 10 cycles after grant.
- Fairness: all `req` held with words 8'hA0..8'hA3 → grant order 0,1,2,3,0 with RR_EN. Without RR_EN the order is 0,0,0.
- Gap: `req[1]` and `req[3]` held, GAP=2 → `ser_valid` low exactly 3 cycles between words; owners alternate 1,3,1.
- Reset mid-word: `rst` pulsed during the 4th `ser_valid` cycle → all outputs 0 immediately. After release, `req[2]`=1 with 8'hA3 → grant `4'b0100` next edge and a full 8-cycle window.
- Enable: `en`=0 with `req[1]` pending → no grant for 20 cycles. Raising `en` → grant next edge. Dropping `en` in SEND cycle 2 → the word still completes all 8 cycles and no further grant is issued.
- Wrap: previous winner 3, then `req[0]` and `req[3]` both set → requester 0 wins with RR_EN.

Source files
------------

// File: rtl/p2s_sched_if.sv
// Requester/converter-side bundle for p2s_sched: arbitration inputs and the
// serial-window outputs that feed one parallel_to_serial converter.
interface p2s_sched_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                      en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          grant;
    logic [DATA_W-1:0]         ser_data;
    logic                      ser_valid;
    logic [PW-1:0]             owner;
    logic                      busy;

    modport master (
        output en, req, req_data,
        input  grant, ser_data, ser_valid, owner, busy
    );

    modport slave (
        input  en, req, req_data,
        output grant, ser_data, ser_valid, owner, busy
    );
endinterface

// File: rtl/p2s_sched.sv
// Scheduler sharing one parallel_to_serial converter among N_REQ requesters.
// Define P2S_SCHED_RR_EN for round-robin; otherwise fixed lowest-index priority.
module p2s_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic         clk,
    input  logic         rst,
    p2s_sched_if.slave   bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(((DATA_W > GAP) ? DATA_W : GAP) + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t              r_state, w_state_next;
    logic [CW-1:0]       r_cnt, w_cnt_next;
    logic [N_REQ-1:0]    r_grant, w_grant_next;
    logic [DATA_W-1:0]   r_data, w_data_next;
    logic [PW-1:0]       r_owner, w_owner_next;
    logic                r_valid, w_valid_next;

    logic [DATA_W-1:0]   w_words [N_REQ];
    logic [N_REQ-1:0]    w_rot;
    logic [PW-1:0]       w_base;
    logic [PW-1:0]       w_win;
    logic                w_hit;
    logic [PW:0]         w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_words
            assign w_words[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef P2S_SCHED_RR_EN
    logic [PW-1:0]       r_ptr;
    logic [2*N_REQ-1:0]  w_req2;

    // Doubling the request vector turns the wrap-around search into a plain slice.
    assign w_req2 = {bus.req, bus.req};
    assign w_rot  = w_req2[r_ptr +: N_REQ];
    assign w_base = r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == S_IDLE && bus.en && w_hit) begin
            r_ptr <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        end
    end
`else
    assign w_rot  = bus.req;
    assign w_base = '0;
`endif

    // Descending scan: the last hit written is the lowest offset from the base.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_hit = 1'b1;
                w_sum = {1'b0, w_base} + (PW+1)'(j);
                if (w_sum >= (PW+1)'(N_REQ)) begin
                    w_sum = w_sum - (PW+1)'(N_REQ);
                end
                w_win = w_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant_next = '0;
        w_data_next  = r_data;
        w_owner_next = r_owner;
        w_valid_next = r_valid;
        case (r_state)
            S_IDLE: begin
                w_valid_next = 1'b0;
                if (bus.en && w_hit) begin
                    w_grant_next = N_REQ'(1) << w_win;
                    w_data_next  = w_words[w_win];
                    w_owner_next = w_win;
                    w_valid_next = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_valid_next = 1'b1;
                w_cnt_next   = r_cnt + 1'b1;
                if (r_cnt == CW'(DATA_W - 1)) begin
                    w_valid_next = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                w_valid_next = 1'b0;
                w_cnt_next   = r_cnt + 1'b1;
                if (r_cnt == CW'(GAP - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_data  <= '0;
            r_owner <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_grant <= w_grant_next;
            r_data  <= w_data_next;
            r_owner <= w_owner_next;
            r_valid <= w_valid_next;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ser_data  = r_data;
    assign bus.ser_valid = r_valid;
    assign bus.owner     = r_owner;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_p2s_sched.sv
// Directed bench for p2s_sched: one instance with GAP=1, one with GAP=2.
// Expected grant orders follow P2S_SCHED_RR_EN when it is defined.
module tb_p2s_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef P2S_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    p2s_sched_if #(.N_REQ(4), .DATA_W(8)) b1 ();
    p2s_sched_if #(.N_REQ(4), .DATA_W(8)) b2 ();

    p2s_sched #(.N_REQ(4), .DATA_W(8), .GAP(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    p2s_sched #(.N_REQ(4), .DATA_W(8), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_g1(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (b1.grant == 0 && cyc < max);
    endtask

    // Starts on a grant cycle; returns the valid-window length, data slips and stray grants.
    task automatic count_v1(input logic [7:0] d, output int n, output int bad, output int gx);
        n = 0; bad = 0; gx = 0;
        while (b1.ser_valid === 1'b1 && n < 40) begin
            n++;
            if (b1.ser_data !== d) bad++;
            if (n > 1 && b1.grant != 0) gx++;
            tick();
        end
    endtask

    int c, n, bad, gx, g, lo, exp_o;
    logic [7:0] exp_d;

    initial begin
        b1.en = 1'b0; b1.req = '0; b1.req_data = '0;
        b2.en = 1'b0; b2.req = '0; b2.req_data = '0;
        repeat (2) tick();
        check("rst_outputs", {b1.grant, b1.ser_valid, b1.ser_data, b1.owner, b1.busy}, 0);
        rst = 1'b0;
        tick();

        // Single requester
        b1.en = 1'b1; b1.req = 4'b0001; b1.req_data[7:0] = 8'hF0;
        wait_g1(5, c);
        check("single_latency", c, 1);
        check("single_grant", b1.grant, 4'b0001);
        check("single_owner", b1.owner, 0);
        check("single_data", b1.ser_data, 8'hF0);
        check("single_busy_hi", b1.busy, 1);
        b1.req = '0;
        count_v1(8'hF0, n, bad, gx);
        check("single_window", n, 8);
        check("single_data_hold", bad, 0);
        check("single_grant_pulse", gx, 0);
        check("single_gap_busy", b1.busy, 1);
        tick();
        check("single_busy_drop", b1.busy, 0);
        check("single_data_kept", b1.ser_data, 8'hF0);

        // Fairness from a freshly reset pointer
        rst = 1'b1; #2; rst = 1'b0;
        b1.req = 4'b1111; b1.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            wait_g1(20, c);
            exp_o = RR ? (i % 4) : 0;
            exp_d = 8'hA0 + 8'(exp_o);
            check($sformatf("fair%0d_interval", i), c, (i == 0) ? 1 : 10);
            check($sformatf("fair%0d_owner", i), b1.owner, exp_o);
            check($sformatf("fair%0d_grant", i), b1.grant, 1 << exp_o);
            check($sformatf("fair%0d_data", i), b1.ser_data, exp_d);
        end
        b1.req = '0;
        repeat (12) tick();

        // Last winner 0: round-robin now favours 3 over 0
        b1.req = 4'b1001;
        wait_g1(5, c);
        b1.req = '0;
        check("ptr_owner", b1.owner, RR ? 3 : 0);
        repeat (12) tick();

        // Last winner 3: pointer wraps so 0 beats 3
        b1.req = 4'b1001;
        wait_g1(5, c);
        b1.req = '0;
        check("wrap_owner", b1.owner, 0);
        check("wrap_data", b1.ser_data, 8'hA0);
        repeat (12) tick();

        // Enable gating
        b1.en = 1'b0; b1.req = 4'b0010; b1.req_data[15:8] = 8'h5A;
        g = 0;
        repeat (20) begin
            tick();
            if (b1.grant != 0) g++;
        end
        check("en_block", g, 0);
        b1.en = 1'b1;
        wait_g1(3, c);
        check("en_latency", c, 1);
        check("en_grant", b1.grant, 4'b0010);
        tick();
        b1.en = 1'b0;
        // Counting resumes at SEND cycle 2, so 7 more cycles make the full 8.
        count_v1(8'h5A, n, bad, gx);
        check("en_window_rest", n, 7);
        check("en_data_hold", bad, 0);
        g = 0;
        repeat (15) begin
            tick();
            if (b1.grant != 0) g++;
        end
        check("en_no_regrant", g, 0);
        b1.req = '0; b1.en = 1'b1;
        tick();

        // Reset in the 4th valid cycle
        b1.req = 4'b0001; b1.req_data[7:0] = 8'hF0;
        wait_g1(5, c);
        b1.req = '0;
        repeat (3) tick();
        check("midrst_valid_before", b1.ser_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_async_zero", {b1.grant, b1.ser_valid, b1.ser_data, b1.owner, b1.busy}, 0);
        tick();
        rst = 1'b0;
        b1.req = 4'b0100; b1.req_data[23:16] = 8'hA3;
        wait_g1(3, c);
        check("midrst_latency", c, 1);
        check("midrst_grant", b1.grant, 4'b0100);
        check("midrst_owner", b1.owner, 2);
        b1.req = '0;
        count_v1(8'hA3, n, bad, gx);
        check("midrst_window", n, 8);
        check("midrst_data_hold", bad, 0);

        // GAP=2 instance: alternating holders
        b2.en = 1'b1; b2.req = 4'b1010;
        b2.req_data[15:8] = 8'hB1; b2.req_data[31:24] = 8'hB3;
        c = 0;
        do begin
            tick();
            c++;
        end while (b2.grant == 0 && c < 5);
        check("gap_latency", c, 1);
        for (int w = 0; w < 3; w++) begin
            exp_o = (RR && (w % 2 == 1)) ? 3 : 1;
            check($sformatf("gap%0d_owner", w), b2.owner, exp_o);
            check($sformatf("gap%0d_data", w), b2.ser_data, (exp_o == 3) ? 8'hB3 : 8'hB1);
            if (w < 2) begin
                n = 0;
                while (b2.ser_valid === 1'b1 && n < 40) begin
                    n++;
                    tick();
                end
                check($sformatf("gap%0d_window", w), n, 8);
                lo = 0;
                while (b2.ser_valid !== 1'b1 && lo < 40) begin
                    lo++;
                    tick();
                end
                check($sformatf("gap%0d_low", w), lo, 3);
            end
        end
        b2.req = '0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
